// File: rtl/cmd_pkg.sv
// Shared types for the UART command streamer: FSM state encoding and default byte width.
package cmd_pkg;

  localparam int CMD_DATA_W = 8;

  // ST_CSUM is only reachable when CMD_STREAM_CSUM_EN is defined.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_SEND  = 3'd2,
    ST_GAP   = 3'd3,
    ST_CSUM  = 3'd4,
    ST_FIN   = 3'd5
  } cmd_state_e;

endpackage

// File: rtl/cmd_buf.sv
// Command buffer: DEPTH x DATA_W simple dual-port RAM, one write port and a registered read port.
module cmd_buf
  import cmd_pkg::*;
#(
  parameter int DATA_W = CMD_DATA_W,
  parameter int DEPTH  = 64,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Contents and read register are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/cmd_stream_tx.sv
// Command streamer: sends buffer bytes 0..len-1 to the UART TX over valid/ready with a fixed gap.
// Define CMD_STREAM_CSUM_EN to append an XOR checksum byte after the payload.
module cmd_stream_tx
  import cmd_pkg::*;
#(
  parameter  int DATA_W     = CMD_DATA_W,
  parameter  int DEPTH      = 64,
  parameter  int GAP_CYCLES = 10,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic              baud_clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW:0]       len,
  input  logic              start,
  input  logic              abort,
  output logic              tx_valid,
  output logic [DATA_W-1:0] tx_data,
  input  logic              tx_ready,
  output logic              busy,
  output logic              done
);

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [AW:0]   DEPTH_C  = {1'b1, {AW{1'b0}}};
  localparam logic [AW:0]   IDX_ONE  = {{AW{1'b0}}, 1'b1};

  cmd_state_e        state_q, state_d;
  logic [AW:0]       idx_q, idx_d;
  logic [AW:0]       cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              abort_q, abort_d;
  logic [AW:0]       len_clamped;
  logic [AW:0]       idx_inc;
  logic [DATA_W-1:0] rd_data;
`ifdef CMD_STREAM_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_d;
`endif

  // Writes only land while idle so a running transfer sees a frozen snapshot.
  cmd_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_buf (
    .clk_i   (baud_clk),
    .we_i    (wr_en && (state_q == ST_IDLE)),
    .waddr_i (wr_addr),
    .wdata_i (wr_data),
    .re_i    (state_q == ST_FETCH),
    .raddr_i (idx_q[AW-1:0]),
    .rdata_o (rd_data)
  );

  assign len_clamped = (len > DEPTH_C) ? DEPTH_C : len;
  assign idx_inc     = idx_q + IDX_ONE;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    abort_d = abort_q | abort;
`ifdef CMD_STREAM_CSUM_EN
    csum_d  = csum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        abort_d = 1'b0;
        if (start) begin
          cnt_d   = len_clamped;
          idx_d   = '0;
`ifdef CMD_STREAM_CSUM_EN
          csum_d  = '0;
`endif
          state_d = (len_clamped == '0) ? ST_FIN : ST_FETCH;
        end
      end
      ST_FETCH: begin
        state_d = abort_d ? ST_FIN : ST_SEND;
      end
      ST_SEND: begin
        if (tx_ready) begin
          idx_d = idx_inc;
          gap_d = '0;
`ifdef CMD_STREAM_CSUM_EN
          csum_d = csum_q ^ rd_data;
`endif
          if (idx_inc == cnt_q) begin
`ifdef CMD_STREAM_CSUM_EN
            state_d = (GAP_CYCLES == 0) ? ST_CSUM : ST_GAP;
`else
            state_d = ST_FIN;
`endif
          end else begin
            state_d = (GAP_CYCLES == 0) ? ST_FETCH : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        // idx == cnt here means the payload is finished and only the checksum remains.
        if (gap_q == GAP_LAST) begin
          if (abort_d) begin
            state_d = ST_FIN;
`ifdef CMD_STREAM_CSUM_EN
          end else if (idx_q == cnt_q) begin
            state_d = ST_CSUM;
`endif
          end else begin
            state_d = ST_FETCH;
          end
        end else begin
          gap_d = gap_q + GAP_ONE;
        end
      end
`ifdef CMD_STREAM_CSUM_EN
      ST_CSUM: begin
        if (tx_ready) begin
          state_d = ST_FIN;
        end
      end
`endif
      ST_FIN: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
      default: begin
        abort_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      gap_q   <= '0;
      abort_q <= 1'b0;
`ifdef CMD_STREAM_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      abort_q <= abort_d;
`ifdef CMD_STREAM_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  // Outputs decode the state register, so reset drops tx_valid without waiting for a clock.
  always_comb begin
    tx_valid = 1'b0;
    tx_data  = '0;
    if (state_q == ST_SEND) begin
      tx_valid = 1'b1;
      tx_data  = rd_data;
    end
`ifdef CMD_STREAM_CSUM_EN
    if (state_q == ST_CSUM) begin
      tx_valid = 1'b1;
      tx_data  = csum_q;
    end
`endif
  end

  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_FIN);

endmodule

// File: tb/tb_cmd_stream_tx.sv
// Directed self-checking bench for cmd_stream_tx (DEPTH=8, GAP_CYCLES=2); checksum cases need CMD_STREAM_CSUM_EN.
module tb_cmd_stream_tx;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int GAP    = 2;
  localparam int AW     = 3;
`ifdef CMD_STREAM_CSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  // Extra cycles before done when a checksum byte follows the payload: gap plus one CSUM cycle.
  localparam int CSX = CS * (GAP + 1);

  logic              baud_clk = 1'b0;
  logic              rst_n    = 1'b0;
  logic              wr_en    = 1'b0;
  logic [AW-1:0]     wr_addr  = '0;
  logic [DATA_W-1:0] wr_data  = '0;
  logic [AW:0]       len      = '0;
  logic              start    = 1'b0;
  logic              abort    = 1'b0;
  logic              tx_ready = 1'b0;
  logic              tx_valid;
  logic [DATA_W-1:0] tx_data;
  logic              busy;
  logic              done;

  always #5 baud_clk = ~baud_clk;

  cmd_stream_tx #(
    .DATA_W     (DATA_W),
    .DEPTH      (DEPTH),
    .GAP_CYCLES (GAP)
  ) dut (
    .baud_clk (baud_clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .len      (len),
    .start    (start),
    .abort    (abort),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .busy     (busy),
    .done     (done)
  );

  int n_chk  = 0;
  int n_pass = 0;

  int          n_hs, done_cyc, n_done, stall_n, stall_bad;
  logic        valid_seen, busy1, busy_after;
  logic [7:0]  stall_data;
  logic [7:0]  hs_data [32];
  int          hs_cyc  [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic wr(input int a, input int d);
    wr_en   = 1'b1;
    wr_addr = a[AW-1:0];
    wr_data = d[7:0];
    @(posedge baud_clk); #1;
    wr_en   = 1'b0;
  endtask

  // Start pulse is cycle 0. Ready is low for cycles [lo_from, lo_to); abort pulses at abort_at;
  // at poke_at a start plus write to addr 1 is issued; same_wr adds a write/abort on the start cycle.
  task automatic xfer(input int l, input int lo_from, input int lo_to, input int abort_at,
                      input int poke_at, input bit same_wr, input int budget);
    n_hs = 0; done_cyc = -1; n_done = 0; stall_n = 0; stall_bad = 0;
    valid_seen = 1'b0; busy1 = 1'bx; busy_after = 1'bx; stall_data = 'x;
    len = l[AW:0]; start = 1'b1; tx_ready = 1'b1;
    if (same_wr) begin
      wr_en = 1'b1; wr_addr = '0; wr_data = 8'h55; abort = 1'b1;
    end
    @(posedge baud_clk); #1;
    start = 1'b0; wr_en = 1'b0; abort = 1'b0;
    for (int c = 1; c <= budget; c++) begin
      tx_ready = !(c >= lo_from && c < lo_to);
      abort    = (c == abort_at);
      if (c == poke_at) begin
        start = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 8'hEE;
      end else begin
        start = 1'b0; wr_en = 1'b0;
      end
      @(negedge baud_clk);
      if (c == 1) busy1 = busy;
      if (tx_valid) valid_seen = 1'b1;
      if (tx_valid && tx_ready && n_hs < 32) begin
        hs_data[n_hs] = tx_data; hs_cyc[n_hs] = c; n_hs++;
      end
      if (tx_valid && !tx_ready) begin
        if (stall_n == 0) stall_data = tx_data;
        else if (tx_data !== stall_data) stall_bad++;
        stall_n++;
      end
      if (done) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc >= 0 && c == done_cyc + 1) busy_after = busy;
      @(posedge baud_clk); #1;
      if (done_cyc >= 0 && c >= done_cyc + 3) break;
    end
    start = 1'b0; wr_en = 1'b0; abort = 1'b0; tx_ready = 1'b0;
    $display("xfer len=%0d bytes=%0d done_cycle=%0d done_pulses=%0d", l, n_hs, done_cyc, n_done);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    @(posedge baud_clk); @(posedge baud_clk); #1;
    rst_n = 1'b1;
    @(posedge baud_clk); #1;

    for (int k = 0; k < 4; k++) wr(k, 8'h10 + k);

    // Basic stream, ready always high
    xfer(4, 0, 0, -1, -1, 1'b0, 60);
    chk("t1_nbytes", n_hs, 4 + CS);
    chk("t1_b0", hs_data[0], 8'h10);
    chk("t1_b1", hs_data[1], 8'h11);
    chk("t1_b2", hs_data[2], 8'h12);
    chk("t1_b3", hs_data[3], 8'h13);
    chk("t1_cyc0", hs_cyc[0], 2);
    chk("t1_cyc1", hs_cyc[1], 6);
    chk("t1_cyc3", hs_cyc[3], 14);
    chk("t1_done_cyc", done_cyc, 15 + CSX);
    chk("t1_done_pulses", n_done, 1);
    chk("t1_busy_c1", busy1, 1'b1);
    chk("t1_busy_after", busy_after, 1'b0);
`ifdef CMD_STREAM_CSUM_EN
    chk("t1_csum", hs_data[4], 8'h00);
`endif

    // Back-pressure on byte 1 for 5 cycles
    xfer(4, 6, 11, -1, -1, 1'b0, 60);
    chk("t2_stall_n", stall_n, 5);
    chk("t2_stall_data", stall_data, 8'h11);
    chk("t2_stall_stable", stall_bad, 0);
    chk("t2_nbytes", n_hs, 4 + CS);
    chk("t2_b1", hs_data[1], 8'h11);
    chk("t2_b2", hs_data[2], 8'h12);
    chk("t2_cyc1", hs_cyc[1], 11);
    chk("t2_done_cyc", done_cyc, 20 + CSX);

    // Abort while byte 2 waits for ready
    xfer(4, 10, 13, 11, -1, 1'b0, 60);
    chk("t3_nbytes", n_hs, 3);
    chk("t3_b2", hs_data[2], 8'h12);
    chk("t3_cyc2", hs_cyc[2], 13);
    chk("t3_done_cyc", done_cyc, 16);
    chk("t3_done_pulses", n_done, 1);

    // start and wr_en while busy have no effect
    xfer(4, 0, 0, -1, 3, 1'b0, 60);
    chk("t4_nbytes", n_hs, 4 + CS);
    chk("t4_b1", hs_data[1], 8'h11);
    chk("t4_done_cyc", done_cyc, 15 + CSX);
    chk("t4_done_pulses", n_done, 1);
    xfer(4, 0, 0, -1, -1, 1'b0, 60);
    chk("t4b_b1_orig", hs_data[1], 8'h11);

    // Write, start and abort in the same idle cycle
    xfer(4, 0, 0, -1, -1, 1'b1, 60);
    chk("t5_b0_new", hs_data[0], 8'h55);
    chk("t5_nbytes", n_hs, 4 + CS);
    chk("t5_done_cyc", done_cyc, 15 + CSX);

    // len = 0
    xfer(0, 0, 0, -1, -1, 1'b0, 20);
    chk("t6_done_cyc", done_cyc, 1);
    chk("t6_no_valid", valid_seen, 1'b0);
    chk("t6_nbytes", n_hs, 0);
    chk("t6_busy_after", busy_after, 1'b0);

    // len = DEPTH+1 clamps to DEPTH
    for (int k = 0; k < DEPTH; k++) wr(k, 8'h20 + k);
    xfer(DEPTH + 1, 0, 0, -1, -1, 1'b0, 80);
    chk("t7_nbytes", n_hs, DEPTH + CS);
    chk("t7_b0", hs_data[0], 8'h20);
    chk("t7_last", hs_data[DEPTH-1], 8'h27);
    chk("t7_done_cyc", done_cyc, 31 + CSX);

    // Asynchronous reset mid-transfer
    len = 4'd4; start = 1'b1; tx_ready = 1'b0;
    @(posedge baud_clk); #1;
    start = 1'b0;
    @(posedge baud_clk); #1;
    chk("t8_valid_before", tx_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("t8_valid_async", tx_valid, 1'b0);
    chk("t8_data_async", tx_data, 8'h00);
    chk("t8_busy_async", busy, 1'b0);
    @(posedge baud_clk); #1;
    rst_n = 1'b1;
    @(posedge baud_clk); #1;
    $display("async reset mid-transfer applied");

`ifdef CMD_STREAM_CSUM_EN
    // Checksum byte after payload
    wr(0, 8'hA5); wr(1, 8'h0F); wr(2, 8'h30);
    xfer(3, 0, 0, -1, -1, 1'b0, 60);
    chk("t9_nbytes", n_hs, 4);
    chk("t9_b2", hs_data[2], 8'h30);
    chk("t9_csum", hs_data[3], 8'h9A);
    chk("t9_csum_cyc", hs_cyc[3], 13);
    chk("t9_done_cyc", done_cyc, 14);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cmd_stream_tx.md
# cmd_stream_tx

Parametrised command streamer for the UART transmit path. Holds a command buffer loaded through a write port and, on a start pulse, streams bytes 0..len-1 to the UART transmitter over a valid/ready handshake, with a programmable minimum gap between bytes. It replaces fixed-count pacing with back-pressure, and adds busy/done status and abort. It sits between the command-building logic and the UART TX serialiser, all in the `baud_clk` domain.

## Interface
- `DATA_W`, 8: byte width of buffer entries and `tx_data`.
- `DEPTH`, 64: buffer entries; power of two, ≥2. `AW = $clog2(DEPTH)`.
- `GAP_CYCLES`, 10: idle cycles inserted after each accepted byte; 0 allowed.

- `baud_clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `wr_en`  in  1  buffer write strobe.
- `wr_addr`  in  AW  buffer write address.
- `wr_data`  in  DATA_W  buffer write data.
- `len`  in  AW+1  byte count, sampled on `start`.
- `start`  in  1  begin a transfer; honoured only in IDLE.
- `abort`  in  1  stop the transfer at the next byte boundary.
- `tx_valid`  out  1  byte offered to the UART.
- `tx_data`  out  DATA_W  offered byte.
- `tx_ready`  in  1  UART accepts the byte when high together with `tx_valid`.
- `busy`  out  1  high from the cycle after `start` until `done`.
- `done`  out  1  one-cycle pulse at the end of a transfer, completed or aborted.

## Operation
- States: IDLE, FETCH, SEND, GAP, CSUM (only with the macro), FIN.
- IDLE: `start`=1 latches `min(len, DEPTH)` into `cnt` and clears `idx` and `csum`. If the latched count is 0, go to FIN. Otherwise go to FETCH.
- FETCH: one-cycle registered buffer read at `idx`. Next state is SEND.
- SEND: `tx_valid`=1 and `tx_data`=buf[idx]. Both hold stable until `tx_ready`=1. On the handshake: `idx++` and `csum ^= tx_data`.
  - If the handshake took the last byte, go to CSUM (macro set) or FIN.
  - Else if `GAP_CYCLES`=0, go to FETCH.
  - Else go to GAP.
- GAP: counts `GAP_CYCLES` cycles, then goes to FETCH. If `abort` was latched, it goes to FIN instead.
- FIN: `done`=1 for one cycle, then IDLE.
- `abort` is latched as a sticky flag while busy. It is acted on only in FETCH or GAP, never while `tx_valid`=1, so a handshake is never withdrawn. In FETCH it goes directly to FIN.
- Writes: `wr_en` is accepted in IDLE only and ignored while `busy`=1, so a transfer always sends a consistent snapshot. A write and `start` in the same IDLE cycle: the write lands, and the transfer reads the new value.
- `start` while busy is ignored and not queued. `start` and `abort` in the same IDLE cycle: `abort` is ignored and the transfer runs.
- Index arithmetic: `idx` is AW+1 bits wide and compared to `cnt`; there is no wrap. `len`>DEPTH clamps to DEPTH.

## Timing
- Reset values: `tx_valid`=0, `tx_data`=0, `busy`=0, `done`=0, state IDLE, `idx`=0, `cnt`=0, `csum`=0, abort flag 0.
- `rst_n` low mid-transfer drops `tx_valid` immediately (asynchronously). The buffer contents are undefined after reset.
- `start` at cycle 0: `busy`=1 at cycle 1 (FETCH), `tx_valid`=1 at cycle 2.
- Byte period with `tx_ready` held high: 2 + `GAP_CYCLES` cycles.
- After the final handshake at cycle t: `done`=1 at t+1, `busy`=0 at t+2. With the checksum enabled, the FIN step follows the checksum handshake instead.
- `len`=0: `done` at cycle 1 with no `tx_valid`.

## Configuration
- `CMD_STREAM_CSUM_EN` defined: after the last payload byte, a GAP, then CSUM.
  - CSUM holds `tx_valid`=1 with `tx_data`=XOR of all payload bytes until the handshake, then goes to FIN.
  - `len`=0 sends no checksum.
  - An abort suppresses the checksum.
- Undefined: the CSUM state and `csum` register are absent; the transfer goes straight to FIN after the last byte.

## Structure
- Package `cmd_pkg` holds the state enum `cmd_state_e` and the default `DATA_W`.
- Sub-module `cmd_buf` is a DEPTH×DATA_W simple dual-port RAM: one write port and a registered read port. No reset on its contents.

## Test plan
- Load bytes 0x10..0x13, `len`=4, `GAP_CYCLES`=2, `tx_ready`=1 -> `tx_data` 0x10,0x11,0x12,0x13 at cycles 2,6,10,14; `done` at 15.
- Same load, `tx_ready` low for 5 cycles while byte 1 is offered -> `tx_valid` and `tx_data`=0x11 held stable; no byte lost or duplicated.
- `len`=0 -> `done` at cycle 1, `tx_valid` never asserted. `len`=DEPTH+1 -> exactly DEPTH bytes sent.
- `abort` pulsed while byte 2 of 4 is waiting for `tx_ready` -> byte 2 completes, byte 3 is not sent, `done` pulses once.
- `start` and `wr_en` asserted while busy -> no effect on the current stream. A following transfer sends the original data.
- With `CMD_STREAM_CSUM_EN`: bytes 0xA5,0x0F,0x30 -> a fourth byte 0x9A, then `done`.
